// File: rtl/traffic_sensor_cond_if.sv
// Signal bundle between the loop-detector front end and the sensor conditioner.
// The slave side is the conditioner; the master side drives detectors and reads status.
interface traffic_sensor_cond_if #(
    parameter int CAR_W = 8
);
    logic             raw_a;
    logic             raw_b;
    logic             cnt_clr;
    logic             Ta;
    logic             Tb;
    logic [CAR_W-1:0] car_cnt_a;
    logic [CAR_W-1:0] car_cnt_b;

    modport master (
        output raw_a,
        output raw_b,
        output cnt_clr,
        input  Ta,
        input  Tb,
        input  car_cnt_a,
        input  car_cnt_b
    );

    modport slave (
        input  raw_a,
        input  raw_b,
        input  cnt_clr,
        output Ta,
        output Tb,
        output car_cnt_a,
        output car_cnt_b
    );
endinterface

// File: rtl/traffic_sensor_cond.sv
// Traffic sensor conditioner: per-street synchronizer, arrival debounce and departure
// hold, producing clean Ta/Tb presence flags plus saturating arrival counters.
// Channel index 0 is street A, index 1 is street B; both channels are identical.
module traffic_sensor_cond #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CAR_W       = 8
) (
    input logic                  clk,
    input logic                  rst,
    traffic_sensor_cond_if.slave bus
);
    localparam int MAX_CYC = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0]    DEB_LAST  = TW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]    T_ONE     = TW'(1);
    localparam logic [CAR_W-1:0] CNT_MAX   = '1;
    localparam logic [CAR_W-1:0] CNT_ONE   = CAR_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DEB     = 2'b01,
        PRESENT = 2'b10,
        HOLD    = 2'b11
    } state_t;

    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    state_t           state    [2];
    state_t           state_nx [2];
    logic [TW-1:0]    timer    [2];
    logic [TW-1:0]    timer_nx [2];
    logic [1:0]       arrive;
    logic [CAR_W-1:0] cnt      [2];

    assign raw = {bus.raw_b, bus.raw_a};

    // Two-flop synchronizer for the asynchronous detector inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Channel state and timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                state[ch] <= IDLE;
                timer[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state[ch] <= state_nx[ch];
                timer[ch] <= timer_nx[ch];
            end
        end
    end

    // Debounce/hold next-state logic; arrive flags a fresh vehicle entering PRESENT.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_nx[ch] = state[ch];
            timer_nx[ch] = timer[ch];
            arrive[ch]   = 1'b0;
            case (state[ch])
                IDLE: begin
                    if (sync2[ch]) begin
                        if (DEB_CYCLES == 1) begin
                            state_nx[ch] = PRESENT;
                            timer_nx[ch] = '0;
                            arrive[ch]   = 1'b1;
                        end else begin
                            state_nx[ch] = DEB;
                            timer_nx[ch] = T_ONE;
                        end
                    end
                end
                DEB: begin
                    if (!sync2[ch]) begin
                        state_nx[ch] = IDLE;
                        timer_nx[ch] = '0;
                    end else if (timer[ch] == DEB_LAST) begin
                        state_nx[ch] = PRESENT;
                        timer_nx[ch] = '0;
                        arrive[ch]   = 1'b1;
                    end else begin
                        timer_nx[ch] = timer[ch] + T_ONE;
                    end
                end
                PRESENT: begin
                    if (!sync2[ch]) begin
                        if (HOLD_CYCLES == 1) begin
                            state_nx[ch] = IDLE;
                            timer_nx[ch] = '0;
                        end else begin
                            state_nx[ch] = HOLD;
                            timer_nx[ch] = T_ONE;
                        end
                    end
                end
                HOLD: begin
                    // A return to high within the hold window is the same vehicle.
                    if (sync2[ch]) begin
                        state_nx[ch] = PRESENT;
                        timer_nx[ch] = '0;
                    end else if (timer[ch] == HOLD_LAST) begin
                        state_nx[ch] = IDLE;
                        timer_nx[ch] = '0;
                    end else begin
                        timer_nx[ch] = timer[ch] + T_ONE;
                    end
                end
                default: begin
                    state_nx[ch] = IDLE;
                    timer_nx[ch] = '0;
                end
            endcase
        end
    end

    // Saturating arrival counters; an arrival coinciding with a clear leaves a count of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                cnt[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (arrive[ch]) begin
                    if (bus.cnt_clr) begin
                        cnt[ch] <= CNT_ONE;
                    end else if (cnt[ch] != CNT_MAX) begin
                        cnt[ch] <= cnt[ch] + CNT_ONE;
                    end
                end else if (bus.cnt_clr) begin
                    cnt[ch] <= '0;
                end
            end
        end
    end

    // Presence is the MSB of the registered state (PRESENT and HOLD).
    assign bus.Ta        = state[0][1];
    assign bus.Tb        = state[1][1];
    assign bus.car_cnt_a = cnt[0];
    assign bus.car_cnt_b = cnt[1];
endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Bench for traffic_sensor_cond: run-length reference model feeding a scoreboard queue,
// a table of segment vectors with hand-computed end states, and hand-written corner sequences.
module tb_traffic_sensor_cond;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    traffic_sensor_cond_if #(.CAR_W(CW)) bus ();

    traffic_sensor_cond #(
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD),
        .CAR_W      (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [2*CW+1:0] act, input logic [2*CW+1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got {Ta,Tb,ca,cb}=%h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [2*CW+1:0] dut_pack();
        return {bus.Ta, bus.Tb, bus.car_cnt_a, bus.car_cnt_b};
    endfunction

    // Reference model: counts consecutive synchronized samples instead of walking states.
    typedef struct {
        logic s1;
        logic s2;
        logic t;
        int   hi;
        int   lo;
        int   cnt;
    } ch_t;

    function automatic ch_t step(input ch_t c, input logic raw, input logic clr);
        ch_t  n   = c;
        logic arr = 1'b0;
        if (c.s2) begin
            n.hi = (c.hi < 100000) ? c.hi + 1 : c.hi;
            n.lo = 0;
        end else begin
            n.lo = (c.lo < 100000) ? c.lo + 1 : c.lo;
            n.hi = 0;
        end
        if (!c.t && n.hi >= DEB) begin
            n.t = 1'b1;
            arr = 1'b1;
        end else if (c.t && n.lo >= HOLD) begin
            n.t = 1'b0;
        end
        if (arr) n.cnt = clr ? 1 : ((c.cnt < CMAX) ? c.cnt + 1 : c.cnt);
        else if (clr) n.cnt = 0;
        n.s2 = c.s1;
        n.s1 = raw;
        return n;
    endfunction

    function automatic logic [2*CW+1:0] mk_exp(input ch_t a, input ch_t b);
        return {a.t, b.t, CW'(a.cnt), CW'(b.cnt)};
    endfunction

    ch_t ma, mb;
    logic [2*CW+1:0] exp_q[$];

    // Model advances on every edge; its post-edge outputs are queued for the scoreboard.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
            exp_q.delete();
        end else begin
            exp_q.push_back(mk_exp(step(ma, bus.raw_a, bus.cnt_clr), step(mb, bus.raw_b, bus.cnt_clr)));
            ma <= step(ma, bus.raw_a, bus.cnt_clr);
            mb <= step(mb, bus.raw_b, bus.cnt_clr);
        end
    end

    // Scoreboard: compare DUT against the queued model result half a cycle after each edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            chk("scoreboard", dut_pack(), exp_q.pop_front());
        end
    end

    typedef struct {
        logic a;
        logic b;
        logic clr;
        int   cyc;
        logic ta;
        logic tb;
        int   ca;
        int   cb;
    } vec_t;

    vec_t tbl[13];

    task automatic pulse(input int ch, input int hi, input int lo);
        if (ch == 0) bus.raw_a = 1'b1; else bus.raw_b = 1'b1;
        repeat (hi) @(negedge clk);
        if (ch == 0) bus.raw_a = 1'b0; else bus.raw_b = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        int left_a, left_b;

        tbl[0]  = '{a:0, b:0, clr:0, cyc:4,  ta:0, tb:0, ca:0, cb:0};
        tbl[1]  = '{a:1, b:0, clr:0, cyc:3,  ta:0, tb:0, ca:0, cb:0};
        tbl[2]  = '{a:0, b:0, clr:0, cyc:6,  ta:0, tb:0, ca:0, cb:0};
        tbl[3]  = '{a:1, b:0, clr:0, cyc:4,  ta:0, tb:0, ca:0, cb:0};
        tbl[4]  = '{a:0, b:0, clr:0, cyc:2,  ta:1, tb:0, ca:1, cb:0};
        tbl[5]  = '{a:0, b:0, clr:0, cyc:3,  ta:1, tb:0, ca:1, cb:0};
        tbl[6]  = '{a:1, b:0, clr:0, cyc:10, ta:1, tb:0, ca:1, cb:0};
        tbl[7]  = '{a:0, b:0, clr:0, cyc:9,  ta:1, tb:0, ca:1, cb:0};
        tbl[8]  = '{a:0, b:0, clr:0, cyc:1,  ta:0, tb:0, ca:1, cb:0};
        tbl[9]  = '{a:0, b:1, clr:0, cyc:6,  ta:0, tb:1, ca:1, cb:1};
        tbl[10] = '{a:0, b:0, clr:0, cyc:10, ta:0, tb:0, ca:1, cb:1};
        tbl[11] = '{a:0, b:0, clr:1, cyc:1,  ta:0, tb:0, ca:0, cb:0};
        tbl[12] = '{a:0, b:0, clr:0, cyc:2,  ta:0, tb:0, ca:0, cb:0};

        rst         = 1'b1;
        bus.raw_a   = 1'b0;
        bus.raw_b   = 1'b0;
        bus.cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", dut_pack(), '0);
        rst = 1'b0;

        // Reset asserted while A is in HOLD with a count of five.
        repeat (4) pulse(0, 6, 10);
        pulse(0, 6, 3);
        chk("pre_rst_hold", dut_pack(), {1'b1, 1'b0, CW'(5), CW'(0)});
        #2 rst = 1'b1;
        #1 chk("async_rst", dut_pack(), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", dut_pack(), '0);

        // Segment table: debounce latency, short pulse, gap bridging, channel B, clear.
        for (int i = 0; i < 13; i++) begin
            bus.raw_a   = tbl[i].a;
            bus.raw_b   = tbl[i].b;
            bus.cnt_clr = tbl[i].clr;
            repeat (tbl[i].cyc) @(negedge clk);
            chk($sformatf("tbl%0d", i), dut_pack(),
                {tbl[i].ta, tbl[i].tb, CW'(tbl[i].ca), CW'(tbl[i].cb)});
        end
        bus.cnt_clr = 1'b0;

        // Saturation on B, then plain clear, then clear coinciding with an arrival.
        repeat (260) pulse(1, 6, 10);
        chk("sat_255", {2'b00, bus.car_cnt_b}, {2'b00, CW'(CMAX)});
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        chk("clr_alone", {2'b00, bus.car_cnt_b}, '0);
        repeat (2) pulse(1, 6, 10);
        chk("recount_2", {2'b00, bus.car_cnt_b}, {2'b00, CW'(2)});
        bus.raw_b = 1'b1;
        repeat (5) @(negedge clk);
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        chk("clr_with_arrival", {1'b0, bus.Tb, bus.car_cnt_b}, {1'b0, 1'b1, CW'(1)});
        bus.raw_b = 1'b0;
        repeat (12) @(negedge clk);

        // Independent random activity on both streets; scoreboard checks every cycle.
        left_a = 0;
        left_b = 0;
        for (int c = 0; c < 1500; c++) begin
            if (left_a == 0) begin
                bus.raw_a = ~bus.raw_a;
                left_a    = $urandom_range(1, 12);
            end
            if (left_b == 0) begin
                bus.raw_b = ~bus.raw_b;
                left_b    = $urandom_range(1, 12);
            end
            left_a--;
            left_b--;
            bus.cnt_clr = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        bus.raw_a   = 1'b0;
        bus.raw_b   = 1'b0;
        bus.cnt_clr = 1'b0;
        repeat (20) @(negedge clk);
        chk("final_idle", {bus.Ta, bus.Tb}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
